// File: rtl/sram_like_responder.sv
// SRAM-like target: accepts requests, forwards them to a synchronous RAM in order and
// answers each one with a single in-order data_ok pulse at least LAT cycles after acceptance.
module sram_like_responder #(
    parameter int LAT   = 1,
    parameter int OUTST = 2,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_en,
    input  logic          req_wr,
    input  logic [1:0]    req_size,
    input  logic [3:0]    req_wen,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          addr_ok,
    output logic          data_ok,
    output logic [31:0]   rdata,
    input  logic          resp_hold,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);
    localparam logic [1:0] LAST_IDX = 2'(OUTST - 1);
    localparam logic [2:0] CNT_MAX  = 3'(OUTST);
    localparam logic [2:0] LAT_AGE  = 3'(LAT);

    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic [3:0]  vld_q, vld_d;
    logic [3:0]  wr_q, wr_d;
    logic [31:0] data_q [4];
    logic [31:0] data_d [4];
    logic [2:0]  age_q [4];
    logic [2:0]  age_d [4];
    logic        pend_q, pend_d;
    logic [1:0]  pend_idx_q, pend_idx_d;
    logic        accept_s;
    logic        pop_s;
    logic [31:0] head_data_s;
    logic        unused_s;

    // Handshake decode; a read whose RAM data arrives this cycle is forwarded directly
    always_comb begin
        pop_s    = vld_q[head_q] && (age_q[head_q] >= LAT_AGE) && !resp_hold;
        accept_s = resetn && req_en && ((cnt_q < CNT_MAX) || pop_s);
        if (pend_q && (pend_idx_q == head_q)) begin
            head_data_s = ram_rdata;
        end else begin
            head_data_s = data_q[head_q];
        end
    end

    assign addr_ok   = accept_s;
    assign data_ok   = pop_s;
    assign rdata     = (pop_s && !wr_q[head_q]) ? head_data_s : 32'h0000_0000;
    assign ram_en    = accept_s;
    assign ram_we    = (accept_s && req_wr) ? req_wen : 4'h0;
    assign ram_addr  = req_addr[AW+1:2];
    assign ram_wdata = req_wdata;
    assign unused_s  = ^{req_size, req_addr[1:0], req_addr[31:AW+2]};

    // Queue update order: age, late read-data capture, pop, then push (push wins a shared slot)
    always_comb begin
        vld_d      = vld_q;
        wr_d       = wr_q;
        head_d     = head_q;
        tail_d     = tail_q;
        pend_d     = 1'b0;
        pend_idx_d = pend_idx_q;
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
            if (vld_q[i] && (age_q[i] != 3'd7)) begin
                age_d[i] = age_q[i] + 3'd1;
            end else begin
                age_d[i] = age_q[i];
            end
        end
        if (pend_q) begin
            data_d[pend_idx_q] = ram_rdata;
        end else begin
            data_d[pend_idx_q] = data_q[pend_idx_q];
        end
        if (pop_s) begin
            vld_d[head_q] = 1'b0;
            head_d        = (head_q == LAST_IDX) ? 2'd0 : head_q + 2'd1;
        end else begin
            head_d = head_q;
        end
        if (accept_s) begin
            vld_d[tail_q]  = 1'b1;
            wr_d[tail_q]   = req_wr;
            data_d[tail_q] = 32'h0000_0000;
            age_d[tail_q]  = 3'd1;
            tail_d         = (tail_q == LAST_IDX) ? 2'd0 : tail_q + 2'd1;
            pend_d         = !req_wr;
            pend_idx_d     = tail_q;
        end else begin
            tail_d = tail_q;
        end
        case ({accept_s, pop_s})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset discards every outstanding entry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= 3'd0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            vld_q      <= 4'h0;
            wr_q       <= 4'h0;
            pend_q     <= 1'b0;
            pend_idx_q <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= 32'h0000_0000;
                age_q[i]  <= 3'd0;
            end
        end else begin
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            vld_q      <= vld_d;
            wr_q       <= wr_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end
endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: instance A (LAT=1, OUTST=2) and instance B (LAT=3, OUTST=4),
// each with its own RAM, checked against a queue-based model of in-order timed responses.
module tb_sram_like_responder;
    localparam int LAT_A = 1;
    localparam int OUT_A = 2;
    localparam int LAT_B = 3;
    localparam int OUT_B = 4;

    typedef struct { int acc; bit wr; logic [31:0] data; } resp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        a_en = 1'b0, b_en = 1'b0, req_wr = 1'b0, resp_hold = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [3:0]  req_wen = 4'h0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        a_aok, a_dok, b_aok, b_dok, a_ram_en, b_ram_en;
    logic [31:0] a_rdata, b_rdata, a_ram_wdata, b_ram_wdata;
    logic [31:0] a_ram_rdata = 32'h0, b_ram_rdata = 32'h0;
    logic [3:0]  a_ram_we, b_ram_we;
    logic [15:0] a_ram_addr, b_ram_addr;
    logic [31:0] ram_a [256];
    logic [31:0] ram_b [256];
    logic [31:0] sh_a [256];
    logic [31:0] sh_b [256];
    logic        ram_init = 1'b0, sh_init = 1'b0;
    resp_t       q_a[$];
    resp_t       q_b[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    sram_like_responder #(.LAT(LAT_A), .OUTST(OUT_A), .AW(16)) u_dut_a (
        .clk(clk), .resetn(resetn), .req_en(a_en), .req_wr(req_wr), .req_size(req_size),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .addr_ok(a_aok),
        .data_ok(a_dok), .rdata(a_rdata), .resp_hold(resp_hold), .ram_en(a_ram_en),
        .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata));

    sram_like_responder #(.LAT(LAT_B), .OUTST(OUT_B), .AW(16)) u_dut_b (
        .clk(clk), .resetn(resetn), .req_en(b_en), .req_wr(req_wr), .req_size(req_size),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .addr_ok(b_aok),
        .data_ok(b_dok), .rdata(b_rdata), .resp_hold(resp_hold), .ram_en(b_ram_en),
        .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata));

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        return 32'(k) * 32'h9e37_79b9 + 32'h0123_4567;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Model: head is due once LAT cycles have passed since its accept and hold is low
    function automatic bit dok_f(input int id);
        if (!resetn || resp_hold) return 1'b0;
        if (id == 0) begin
            if (q_a.size() == 0) return 1'b0;
            return (cyc - q_a[0].acc) >= LAT_A;
        end
        if (q_b.size() == 0) return 1'b0;
        return (cyc - q_b[0].acc) >= LAT_B;
    endfunction

    function automatic bit aok_f(input int id);
        if (id == 0) return resetn && a_en && ((q_a.size() < OUT_A) || dok_f(0));
        return resetn && b_en && ((q_b.size() < OUT_B) || dok_f(1));
    endfunction

    function automatic logic [31:0] rd_f(input int id);
        if (!dok_f(id)) return 32'h0;
        return (id == 0) ? q_a[0].data : q_b[0].data;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Backing RAMs: one-cycle read latency, noise whenever no read was issued
    always @(posedge clk) begin
        a_ram_rdata <= $urandom;
        b_ram_rdata <= $urandom;
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) begin
                ram_a[i] <= init_word(i);
                ram_b[i] <= init_word(i);
            end
            ram_init <= 1'b1;
        end else begin
            if (a_ram_en) begin
                ram_a[a_ram_addr[7:0]] <= merge(ram_a[a_ram_addr[7:0]], a_ram_wdata, a_ram_we);
                if (a_ram_we == 4'h0) a_ram_rdata <= ram_a[a_ram_addr[7:0]];
            end
            if (b_ram_en) begin
                ram_b[b_ram_addr[7:0]] <= merge(ram_b[b_ram_addr[7:0]], b_ram_wdata, b_ram_we);
                if (b_ram_we == 4'h0) b_ram_rdata <= ram_b[b_ram_addr[7:0]];
            end
        end
    end

    // Model state: shadow memory updated in accept order, response queues stamped with accept cycle
    always @(posedge clk or negedge resetn) begin
        if (!sh_init) begin
            for (int i = 0; i < 256; i++) begin
                sh_a[i] <= init_word(i);
                sh_b[i] <= init_word(i);
            end
            sh_init <= 1'b1;
        end
        if (!resetn) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (aok_f(0)) begin
                q_a.push_back('{acc: cyc, wr: req_wr, data: req_wr ? 32'h0 : sh_a[req_addr[9:2]]});
                if (req_wr) sh_a[req_addr[9:2]] <= merge(sh_a[req_addr[9:2]], req_wdata, req_wen);
            end
            if (dok_f(0)) void'(q_a.pop_front());
            if (aok_f(1)) begin
                q_b.push_back('{acc: cyc, wr: req_wr, data: req_wr ? 32'h0 : sh_b[req_addr[9:2]]});
                if (req_wr) sh_b[req_addr[9:2]] <= merge(sh_b[req_addr[9:2]], req_wdata, req_wen);
            end
            if (dok_f(1)) void'(q_b.pop_front());
        end
    end

    // Drive one cycle of stimulus just after the edge and return at the sampling point
    task automatic drive(input bit a, input bit b, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] wen, input bit hold);
        @(posedge clk);
        #1;
        a_en = a; b_en = b; req_wr = wr; req_addr = addr; req_wdata = wd; req_wen = wen;
        resp_hold = hold; req_size = 2'($urandom_range(0, 2));
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0; a_en = 1'b1; b_en = 1'b1; req_wr = 1'b1; req_wen = 4'hf; req_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if ({a_aok, a_dok, a_ram_en, b_aok, b_dok, b_ram_en} !== 6'b0 || a_rdata !== 32'h0 ||
                b_rdata !== 32'h0 || a_ram_we !== 4'h0 || b_ram_we !== 4'h0)
                $display("FAIL reset_outputs: got aok %b/%b dok %b/%b ram_en %b/%b we %h/%h rdata %h/%h, want all 0",
                         a_aok, b_aok, a_dok, b_dok, a_ram_en, b_ram_en, a_ram_we, b_ram_we, a_rdata, b_rdata);
            else n_pass++;
        end
        req_wr = 1'b0; b_en = 1'b0; resetn = 1'b1;
        #1;
        n_chk++;
        if (a_aok !== 1'b1) $display("FAIL first_accept: addr_ok got %b want 1", a_aok);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        n_chk++;
        if (a_dok !== 1'b1 || a_rdata !== init_word(0))
            $display("FAIL first_read: data_ok %b rdata %h want 1 %h", a_dok, a_rdata, init_word(0));
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic [31:0] exp_rd [3];
        exp_rd = '{32'h0, 32'h0, 32'hdeadbeef};
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            drive(t < 2, 1'b0, t == 0, 32'h100, 32'hdeadbeef, 4'hf, 1'b0);
            n_chk++;
            if (a_dok !== dok_f(0) || a_aok !== aok_f(0) || a_rdata !== rd_f(0))
                $display("FAIL wr_rd_model t%0d: dok/aok/rdata got %b/%b/%h want %b/%b/%h",
                         t, a_dok, a_aok, a_rdata, dok_f(0), aok_f(0), rd_f(0));
            else n_pass++;
            n_chk++;
            if (a_aok !== (t < 2) || a_dok !== (t > 0) || a_rdata !== exp_rd[t])
                $display("FAIL wr_rd t%0d: aok/dok/rdata got %b/%b/%h want %b/%b/%h",
                         t, a_aok, a_dok, a_rdata, t < 2, t > 0, exp_rd[t]);
            else n_pass++;
        end
    endtask

    task automatic test_partial_write();
        drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h11223344, 4'hf, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'h201, 32'h0000ab00, 4'b0010, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h203, 32'h0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        n_chk++;
        if (a_dok !== 1'b1 || a_rdata !== 32'h1122ab44)
            $display("FAIL partial_write: data_ok %b rdata %h want 1 1122ab44", a_dok, a_rdata);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit          en_t   [7] = '{1, 1, 1, 1, 1, 0, 0};
        bit          hold_t [7] = '{1, 1, 1, 1, 0, 0, 0};
        bit          aok_t  [7] = '{1, 1, 0, 0, 1, 0, 0};
        bit          dok_t  [7] = '{0, 0, 0, 0, 1, 1, 1};
        logic [31:0] ad_t   [7] = '{32'h10, 32'h14, 32'h18, 32'h18, 32'h18, 32'h0, 32'h0};
        logic [31:0] rd_t   [7];
        rd_t = '{32'h0, 32'h0, 32'h0, 32'h0, init_word(4), init_word(5), init_word(6)};
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        for (int t = 0; t < 7; t++) begin
            drive(en_t[t], 1'b0, 1'b0, ad_t[t], 32'h0, 4'h0, hold_t[t]);
            n_chk++;
            if (a_aok !== aok_t[t] || a_dok !== dok_t[t] || a_rdata !== rd_t[t])
                $display("FAIL backpressure t%0d: aok/dok/rdata got %b/%b/%h want %b/%b/%h",
                         t, a_aok, a_dok, a_rdata, aok_t[t], dok_t[t], rd_t[t]);
            else n_pass++;
        end
    endtask

    task automatic test_full_wrap();
        logic [31:0] exp_q[$];
        int k = 0, n_acc = 0, n_pop = 0;
        for (int t = 0; t < 26; t++) begin
            drive(t < 23, 1'b0, 1'b0, 32'h300 + 32'(4 * k), 32'h0, 4'h0, t < 3);
            if (a_dok) begin
                n_pop++;
                n_chk++;
                if (exp_q.size() == 0 || a_rdata !== exp_q[0])
                    $display("FAIL wrap_order t%0d: rdata %h want %h", t, a_rdata,
                             exp_q.size() == 0 ? 32'h0 : exp_q[0]);
                else n_pass++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (a_en && a_aok) begin
                exp_q.push_back(init_word(192 + k));
                k++;
                n_acc++;
            end
            if (t == 2 || (t >= 3 && t < 23)) begin
                n_chk++;
                if (a_aok !== (t != 2) || a_dok !== (t != 2))
                    $display("FAIL wrap_stream t%0d: aok/dok got %b/%b want %b/%b", t, a_aok, a_dok, t != 2, t != 2);
                else n_pass++;
            end
        end
        n_chk++;
        if (n_acc != 22 || n_pop != n_acc)
            $display("FAIL wrap_counts: accepts %0d data_ok %0d want 22 22", n_acc, n_pop);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 4'h0, 1'b1);
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) #1; else @(negedge clk);
            resp_hold = 1'b0;
            #1;
            n_chk++;
            if (a_dok !== 1'b0 || a_aok !== 1'b0 || a_ram_en !== 1'b0)
                $display("FAIL mid_reset %0d: dok/aok/ram_en got %b/%b/%b want 0/0/0", i, a_dok, a_aok, a_ram_en);
            else n_pass++;
        end
        @(negedge clk);
        a_en = 1'b0;
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
            n_chk++;
            if (a_dok !== 1'b0) $display("FAIL post_reset_idle %0d: data_ok %b want 0", i, a_dok);
            else n_pass++;
        end
        drive(1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        n_chk++;
        if (a_dok !== 1'b1 || a_rdata !== init_word(18))
            $display("FAIL post_reset_read: dok %b rdata %h want 1 %h", a_dok, a_rdata, init_word(18));
        else n_pass++;
    endtask

    task automatic test_random();
        int n_acc = 0, n_pop = 0;
        for (int t = 0; t < 408; t++) begin
            bit go, hold;
            go   = (t < 400) && ($urandom_range(0, 3) != 0);
            hold = (t < 400) && ($urandom_range(0, 3) == 0);
            drive(go, 1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom,
                  4'($urandom_range(0, 15)), hold);
            n_chk++;
            if (a_dok !== dok_f(0) || a_aok !== aok_f(0) || a_rdata !== rd_f(0))
                $display("FAIL rand_resp t%0d: dok/aok/rdata got %b/%b/%h want %b/%b/%h",
                         t, a_dok, a_aok, a_rdata, dok_f(0), aok_f(0), rd_f(0));
            else n_pass++;
            n_chk++;
            if (a_ram_en !== aok_f(0) || a_ram_we !== ((aok_f(0) && req_wr) ? req_wen : 4'h0) ||
                a_ram_addr !== req_addr[17:2] || a_ram_wdata !== req_wdata)
                $display("FAIL rand_ram t%0d: en/we/addr/wdata got %b/%h/%h/%h want %b/%h/%h/%h",
                         t, a_ram_en, a_ram_we, a_ram_addr, a_ram_wdata, aok_f(0),
                         (aok_f(0) && req_wr) ? req_wen : 4'h0, req_addr[17:2], req_wdata);
            else n_pass++;
            if (a_en && a_aok) n_acc++;
            if (a_dok) n_pop++;
        end
        n_chk++;
        if (n_acc != n_pop) $display("FAIL rand_counts: accepts %0d data_ok %0d", n_acc, n_pop);
        else n_pass++;
    endtask

    task automatic test_lat3();
        logic [31:0] ad_t [3] = '{32'h0, 32'h4, 32'h8};
        for (int t = 0; t < 9; t++) begin
            drive(1'b0, t < 3, 1'b0, (t < 3) ? ad_t[t] : 32'h0, 32'h0, 4'h0, 1'b0);
            n_chk++;
            if (b_dok !== (t >= 3 && t <= 5) || b_aok !== (t < 3) ||
                b_rdata !== ((t >= 3 && t <= 5) ? init_word(t - 3) : 32'h0))
                $display("FAIL lat3 t%0d: dok/aok/rdata got %b/%b/%h want %b/%b/%h", t, b_dok, b_aok, b_rdata,
                         t >= 3 && t <= 5, t < 3, (t >= 3 && t <= 5) ? init_word(t - 3) : 32'h0);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_backpressure();
        test_full_wrap();
        test_reset_mid();
        test_lat3();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sram_like_responder.md
SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 The block SHALL have parameter LAT, default 1, meaning minimum cycles from request accept to data_ok; legal range is 1..7.
REQ-002 The block SHALL have parameter OUTST, default 2, meaning maximum outstanding accepted-but-unanswered transactions; legal range is 1..4.
REQ-003 The block SHALL have parameter AW, default 16, meaning backing RAM word-address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 req_en  input  1  initiator request valid.
REQ-007 req_wr  input  1  1 = write, 0 = read.
REQ-008 req_size  input  2  transfer size: 0 = byte, 1 = half, 2 = word.
REQ-009 req_wen  input  4  byte-lane write strobes.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  write data.
REQ-012 addr_ok  output  1  request accepted this cycle when req_en=1.
REQ-013 data_ok  output  1  one-cycle pulse, one per accepted transaction, in acceptance order.
REQ-014 rdata  output  32  read data, valid only while data_ok=1.
REQ-015 resp_hold  input  1  verification back-pressure; while 1, data_ok is forced low.
REQ-016 ram_en  output  1  backing RAM access enable.
REQ-017 ram_we  output  4  backing RAM byte write enables.
REQ-018 ram_addr  output  AW  backing RAM word address = req_addr[AW+1:2].
REQ-019 ram_wdata  output  32  backing RAM write data = req_wdata.
REQ-020 ram_rdata  input  32  backing RAM read data, valid exactly one cycle after ram_en with ram_we=0.

Function
REQ-021 Occupancy counter cnt (0..OUTST) SHALL track outstanding transactions: +1 on accept, -1 on data_ok, unchanged when both occur in the same cycle.
REQ-022 addr_ok SHALL be the combinational value req_en && (cnt<OUTST || data_ok); accept = req_en && addr_ok.
REQ-023 On accept, the block SHALL drive ram_en=1 in the same cycle, with ram_we = req_wr ? req_wen : 4'h0; otherwise ram_en=0 and ram_we=0.
REQ-024 Each accept SHALL push a response-queue entry {wr, data, age} at the tail of a circular queue of OUTST entries; head and tail pointers SHALL wrap modulo OUTST.
REQ-025 For a read entry, data SHALL be loaded from ram_rdata in the cycle after accept; write entries SHALL hold data=0.
REQ-026 Every valid entry's age SHALL increment each cycle, saturating at 7; age SHALL be 0 in the accept cycle.
REQ-027 data_ok SHALL be 1 iff the queue is non-empty, head age >= LAT, and resp_hold=0; on data_ok the head SHALL pop.
REQ-028 rdata SHALL equal head data when data_ok=1, and 0 otherwise.
REQ-029 With resp_hold=0 and no back-pressure, read latency SHALL be exactly LAT cycles: accept in cycle N gives data_ok in cycle N+LAT.
REQ-030 A read accepted after a write to the same word SHALL return the written bytes, because RAM accesses are issued in acceptance order.
REQ-031 req_addr[1:0] and req_size SHALL NOT alter read data: the full word is returned.
REQ-032 For writes, req_wen SHALL be used verbatim; the block SHALL NOT check it against req_size.
REQ-033 A data_ok pop and an accept push in the same cycle at cnt==OUTST SHALL both complete without loss or duplication.

Reset
REQ-034 While resetn=0, the block SHALL hold: cnt=0, head=tail=0, all entries invalid, addr_ok=0, data_ok=0, rdata=0, ram_en=0, ram_we=0.
REQ-035 Reset asserted mid-transaction SHALL discard all outstanding entries; no data_ok SHALL appear after resetn deasserts unless a new accept occurs.
REQ-036 The first accept SHALL be possible in the first rising edge with resetn=1.

Verification
REQ-037 LAT=1: write addr 0x100, wen 4'hf, data 0xdeadbeef; then read 0x100 -> write data_ok one cycle after accept; read data_ok one cycle after its accept with rdata=0xdeadbeef.
REQ-038 Partial write: wen 4'b0010, data 0x0000ab00 to a word holding 0x11223344 -> subsequent read returns 0x1122ab44.
REQ-039 OUTST=2, resp_hold=1, three back-to-back reads -> addr_ok=1 for the first two requests and 0 for the third; releasing resp_hold gives data_ok pulses in order and the third request is accepted in the first pop cycle.
REQ-040 LAT=3, continuous reads to 0x0, 0x4, 0x8 -> data_ok in cycles N+3, N+4, N+5, each with the matching ram contents.
REQ-041 resetn pulsed low with 2 reads outstanding -> data_ok, addr_ok and ram_en are 0 during reset; no data_ok after release until a new request is accepted.
REQ-042 Full queue with simultaneous pop and push across 20 cycles of pointer wrap -> the count of data_ok pulses equals the count of accepts and read data order is preserved.
